branch_resolver: RTL and testbench
==================================

// Module: branch_resolver
// PURPOSE
//   Counterpart to the 2-bit branch predictor: fetch-side requester and execute-side updater.
//   - Issues request pulses and captures the returned prediction bit.
//   - Queues outstanding predictions in order; compares each against the executed outcome.
//   - Drives result/taken back to the predictor and raises mispredict plus a flush/recover stall.
// PARAMETERS
//   DEPTH        4   max outstanding (unresolved) branches, 2..16
//   CNT_W        16  width of statistics counters
//   FLUSH_CYCLES 2   cycles stall is held high after a mispredict (>=1)
// PORTS
//   clk          in   1        rising-edge clock
//   rst_n        in   1        asynchronous active-low reset
//   fetch_branch in   1        fetch has a branch needing a prediction
//   stall        out  1        fetch must hold; fetch_branch ignored while high
//   request      out  1        to predictor: prediction request pulse
//   prediction   in   1        from predictor: valid the cycle after request
//   pred_valid   out  1        captured prediction available to fetch this cycle
//   pred_taken   out  1        the captured prediction bit
//   exec_valid   in   1        execute resolved the oldest outstanding branch
//   exec_taken   in   1        actual outcome of that branch
//   result       out  1        to predictor: update strobe
//   taken        out  1        to predictor: actual outcome
//   mispredict   out  1        resolved branch disagreed with its prediction
//   queue_level  out  $clog2(DEPTH+1)  reserved entries (pending + captured)
//   err_underrun out  1        sticky: exec_valid with no captured entry
//   branch_count out  CNT_W    branches resolved
//   miss_count   out  CNT_W    mispredicts
// BEHAVIOUR
//   Reset
//   - All outputs 0, queue empty, FSM in RUN; async assert, sync-safe release.
//   Request (cycle T)
//   - fetch_branch & ~stall in T: slot reserved (queue_level+1 at T+1), request=1 in T+1.
//   - prediction sampled at end of T+2 into the reserved slot.
//   - pred_valid=1 / pred_taken in T+3.
//   - Total fetch-to-prediction latency: 3 cycles. request is a 1-cycle pulse per branch.
//   Resolve
//   - exec_valid in cycle R pairs with the oldest captured entry.
//   - In R+1 (registered): result=1, taken=exec_taken, mispredict=(pred != exec_taken).
//   - Entry freed at end of R.
//   Underrun
//   - exec_valid while the oldest entry is empty or still pending sets err_underrun.
//   - No result pulse; cleared only by reset.
//   FSM
//   - RUN: stall = (queue_level == DEPTH); no same-cycle bypass when a resolve frees a slot.
//   - RUN -> RECOVER on a mispredicting resolve.
//   - RECOVER: all entries dropped, including pending ones; in-flight predictions discarded;
//     stall=1 for FLUSH_CYCLES cycles starting R+1; request/pred_valid held 0; then -> RUN.
//   Simultaneous events
//   - fetch + non-mispredicting resolve in the same cycle: both take effect; level unchanged.
//   - fetch in the cycle of a mispredicting resolve: dropped (wrong path); no request issued.
//   - exec_valid in RECOVER: flagged err_underrun.
//   Arithmetic
//   - Queue is a circular buffer; read/write pointers wrap modulo DEPTH.
//   - Counters saturate at 2^CNT_W-1; no wrap.
// CONFIGURATION
//   RESOLVER_STATS_EN defined:
//   - branch_count increments on every resolve; miss_count on every mispredict.
//   RESOLVER_STATS_EN undefined:
//   - Counter registers are not built; branch_count and miss_count are tied to 0.
//   - All other behaviour identical.
// TESTING
//   1. fetch_branch pulse at T0, predictor returns 1
//      -> request=1 @T1; pred_valid=1, pred_taken=1 @T3; queue_level=1.
//   2. DEPTH=4: fetch_branch held high 6 cycles, no resolves
//      -> exactly 4 request pulses; stall=1 from level 4; level stays 4.
//   3. Entry predicted 1, exec_valid=1 with exec_taken=1
//      -> next cycle result=1, taken=1, mispredict=0; level drops by 1.
//   4. 3 entries queued, oldest predicted 0, exec_taken=1
//      -> mispredict=1; level=0; stall=1 for 2 cycles; miss_count=1 (STATS_EN).
//   5. exec_valid on empty queue -> err_underrun=1 sticky, result stays 0.
//   6. rst_n low mid-RECOVER with 2 pending requests
//      -> all outputs 0 immediately; first fetch after release behaves as scenario 1.

Source files
------------

// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver
//   Sits between fetch/execute and a 2-bit branch predictor. It requests a
//   prediction for each fetched branch and keeps the returned bits in an
//   in-order circular queue. When execute resolves the oldest branch, the
//   resolver compares the outcome with the stored prediction. It then reports
//   the outcome to the predictor. On a mispredict it flushes everything and
//   stalls fetch for a fixed recovery window.
//
//   Optional feature macro: RESOLVER_STATS_EN
//     defined   -> saturating branch/mispredict counters are built
//     undefined -> branch_count / miss_count are tied to 0
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset (synchronised release)
//   fetch_branch in   fetch has a branch needing a prediction
//   stall        out  fetch must hold; fetch_branch ignored while high
//   request      out  prediction request pulse to the predictor
//   prediction   in   predictor answer, valid the cycle after request
//   pred_valid   out  captured prediction presented to fetch this cycle
//   pred_taken   out  the captured prediction bit
//   exec_valid   in   execute resolved the oldest outstanding branch
//   exec_taken   in   actual outcome of that branch
//   result       out  update strobe to the predictor
//   taken        out  actual outcome to the predictor
//   mispredict   out  resolved branch disagreed with its prediction
//   queue_level  out  reserved entries (pending + captured)
//   err_underrun out  sticky: resolve with no captured entry available
//   branch_count out  branches resolved (saturating)
//   miss_count   out  mispredicts (saturating)
// ---------------------------------------------------------------------------
module branch_resolver #(
  parameter int DEPTH        = 4,
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_branch,
  output logic                       stall,
  output logic                       request,
  input  logic                       prediction,
  output logic                       pred_valid,
  output logic                       pred_taken,
  input  logic                       exec_valid,
  input  logic                       exec_taken,
  output logic                       result,
  output logic                       taken,
  output logic                       mispredict,
  output logic [$clog2(DEPTH+1)-1:0] queue_level,
  output logic                       err_underrun,
  output logic [CNT_W-1:0]           branch_count,
  output logic [CNT_W-1:0]           miss_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;

  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);
  localparam logic [FC_W-1:0]  FC_ZERO  = {FC_W{1'b0}};
  localparam logic [FC_W-1:0]  FC_LOAD  = FC_W'(FLUSH_CYCLES-1);

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? PTR_ZERO : p + PTR_W'(1);
  endfunction

  logic [1:0]       rst_sync_r;
  logic             rst_int_n_s;

  logic [0:0]       state_r, state_nx;
  logic [FC_W-1:0]  flush_cnt_r, flush_cnt_nx;
  logic [LVL_W-1:0] level_r, level_nx;
  logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r, cap_ptr_r;
  logic [DEPTH-1:0] cap_r;     // slot holds a returned prediction
  logic [DEPTH-1:0] pred_r;    // returned prediction bit per slot
  logic             req_r;     // request in flight (stage 1)
  logic             s2_v_r;    // prediction arrives this cycle (stage 2)
  logic             stall_r, pred_valid_r, pred_taken_r;
  logic             result_r, taken_r, mispredict_r, err_underrun_r;

  logic run_s, accept_s, oldest_ready_s, resolve_s, miss_s;
  logic alloc_s, capture_s, underrun_s;

  // Reset synchroniser: assertion is immediate, release is aligned to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_int_n_s = rst_sync_r[1];

  // Per-cycle event decode.
  always_comb begin
    run_s          = (state_r == ST_RUN);
    accept_s       = fetch_branch & ~stall_r & run_s;
    oldest_ready_s = (level_r != LVL_ZERO) & cap_r[rd_ptr_r];
    resolve_s      = exec_valid & run_s & oldest_ready_s;
    miss_s         = resolve_s & (pred_r[rd_ptr_r] != exec_taken);
    // A fetch in the cycle of a mispredict is on the wrong path.
    alloc_s        = accept_s & ~miss_s;
    capture_s      = s2_v_r & run_s & ~miss_s;
    // Covers empty queue, oldest still pending, and resolves during recovery.
    underrun_s     = exec_valid & ~resolve_s;
  end

  // FSM, recovery counter and occupancy next-state.
  always_comb begin
    state_nx     = state_r;
    flush_cnt_nx = flush_cnt_r;
    level_nx     = level_r;
    case (state_r)
      ST_RUN: begin
        if (miss_s) begin
          state_nx     = ST_RECOVER;
          flush_cnt_nx = FC_LOAD;
          level_nx     = LVL_ZERO;
        end else begin
          level_nx = level_r + LVL_W'(alloc_s) - LVL_W'(resolve_s);
        end
      end
      ST_RECOVER: begin
        level_nx = LVL_ZERO;
        if (flush_cnt_r == FC_ZERO) begin
          state_nx = ST_RUN;
        end else begin
          flush_cnt_nx = flush_cnt_r - FC_W'(1);
        end
      end
      default: begin
        state_nx     = ST_RUN;
        flush_cnt_nx = FC_ZERO;
        level_nx     = LVL_ZERO;
      end
    endcase
  end

  // Queue storage, request pipeline and registered outputs.
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      state_r        <= ST_RUN;
      flush_cnt_r    <= FC_ZERO;
      level_r        <= LVL_ZERO;
      rd_ptr_r       <= PTR_ZERO;
      wr_ptr_r       <= PTR_ZERO;
      cap_ptr_r      <= PTR_ZERO;
      cap_r          <= {DEPTH{1'b0}};
      pred_r         <= {DEPTH{1'b0}};
      req_r          <= 1'b0;
      s2_v_r         <= 1'b0;
      stall_r        <= 1'b0;
      pred_valid_r   <= 1'b0;
      pred_taken_r   <= 1'b0;
      result_r       <= 1'b0;
      taken_r        <= 1'b0;
      mispredict_r   <= 1'b0;
      err_underrun_r <= 1'b0;
    end else begin
      state_r        <= state_nx;
      flush_cnt_r    <= flush_cnt_nx;
      level_r        <= level_nx;
      // Stall is registered from next state, so a resolve never frees a
      // slot for a fetch in the same cycle.
      stall_r        <= (state_nx == ST_RECOVER) | (level_nx == LVL_FULL);
      err_underrun_r <= err_underrun_r | underrun_s;
      result_r       <= resolve_s;
      taken_r        <= resolve_s & exec_taken;
      mispredict_r   <= miss_s;
      if (miss_s) begin
        // Flush: drop every entry and anything still in flight.
        rd_ptr_r     <= PTR_ZERO;
        wr_ptr_r     <= PTR_ZERO;
        cap_ptr_r    <= PTR_ZERO;
        cap_r        <= {DEPTH{1'b0}};
        req_r        <= 1'b0;
        s2_v_r       <= 1'b0;
        pred_valid_r <= 1'b0;
        pred_taken_r <= 1'b0;
      end else begin
        req_r        <= alloc_s;
        s2_v_r       <= req_r & run_s;
        pred_valid_r <= capture_s;
        pred_taken_r <= capture_s & prediction;
        if (alloc_s) begin
          wr_ptr_r <= next_ptr(wr_ptr_r);
        end
        // Capture and resolve never target the same slot: one is pending,
        // the other already captured.
        if (capture_s) begin
          cap_r[cap_ptr_r]  <= 1'b1;
          pred_r[cap_ptr_r] <= prediction;
          cap_ptr_r         <= next_ptr(cap_ptr_r);
        end
        if (resolve_s) begin
          cap_r[rd_ptr_r] <= 1'b0;
          rd_ptr_r        <= next_ptr(rd_ptr_r);
        end
      end
    end
  end

  assign stall        = stall_r;
  assign request      = req_r;
  assign pred_valid   = pred_valid_r;
  assign pred_taken   = pred_taken_r;
  assign result       = result_r;
  assign taken        = taken_r;
  assign mispredict   = mispredict_r;
  assign queue_level  = level_r;
  assign err_underrun = err_underrun_r;

`ifdef RESOLVER_STATS_EN
  logic [CNT_W-1:0] branch_cnt_r, miss_cnt_r;

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      branch_cnt_r <= {CNT_W{1'b0}};
      miss_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (resolve_s && (branch_cnt_r != {CNT_W{1'b1}})) begin
        branch_cnt_r <= branch_cnt_r + CNT_W'(1);
      end
      if (miss_s && (miss_cnt_r != {CNT_W{1'b1}})) begin
        miss_cnt_r <= miss_cnt_r + CNT_W'(1);
      end
    end
  end

  assign branch_count = branch_cnt_r;
  assign miss_count   = miss_cnt_r;
`else
  assign branch_count = {CNT_W{1'b0}};
  assign miss_count   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// ---------------------------------------------------------------------------
// tb_branch_resolver
//   Directed bench with a scoreboard. Stimulus pushes expected predictions
//   and expected resolve results into queues. A negedge monitor pops and
//   compares them whenever pred_valid or result is high. A small predictor
//   model answers each request with a pre-planned bit one cycle later.
// ---------------------------------------------------------------------------
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_branch = 1'b0;
  logic        prediction = 1'b0;
  logic        exec_valid = 1'b0;
  logic        exec_taken = 1'b0;
  logic        stall, request, pred_valid, pred_taken;
  logic        result, taken, mispredict, err_underrun;
  logic [2:0]  queue_level;
  logic [15:0] branch_count, miss_count;

  typedef struct packed {
    logic tk;
    logic mis;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   req_cnt = 0;
  bit   pq[$];        // bits the predictor model will return
  bit   exp_pred[$];  // expected pred_taken per pred_valid
  res_t exp_res[$];   // expected taken/mispredict per result

  branch_resolver #(.DEPTH(4), .CNT_W(16), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_branch(fetch_branch), .stall(stall),
    .request(request), .prediction(prediction), .pred_valid(pred_valid),
    .pred_taken(pred_taken), .exec_valid(exec_valid), .exec_taken(exec_taken),
    .result(result), .taken(taken), .mispredict(mispredict),
    .queue_level(queue_level), .err_underrun(err_underrun),
    .branch_count(branch_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic int exp_stat(input int v);
`ifdef RESOLVER_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Predictor model: answer each request one cycle later.
  always @(posedge clk) begin
    if (request === 1'b1) begin
      req_cnt++;
      #1;
      if (pq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL predictor_request: got request required none");
      end else begin
        prediction = pq.pop_front();
      end
    end
  end

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (pred_valid === 1'b1) begin
      checks++;
      if (exp_pred.size() == 0) begin
        errors++;
        $display("FAIL sb_pred_valid: got unexpected pred_valid required none");
      end else begin
        bit e;
        e = exp_pred.pop_front();
        if (pred_taken !== e) begin
          errors++;
          $display("FAIL sb_pred_taken: got %0b required %0b", pred_taken, e);
        end
      end
    end
    if (result === 1'b1) begin
      checks++;
      if (exp_res.size() == 0) begin
        errors++;
        $display("FAIL sb_result: got unexpected result required none");
      end else begin
        res_t e;
        e = exp_res.pop_front();
        if ((taken !== e.tk) || (mispredict !== e.mis)) begin
          errors++;
          $display("FAIL sb_resolve: got taken=%0b mis=%0b required taken=%0b mis=%0b",
                   taken, mispredict, e.tk, e.mis);
        end
      end
    end
  end

  // One branch predicted taken, then resolved taken.
  task automatic scenario1(input string tag);
    pq.push_back(1'b1);
    exp_pred.push_back(1'b1);
    fetch_branch = 1'b1;
    tick();                                   // now T+1
    fetch_branch = 1'b0;
    chk({tag, "_request_t1"}, 32'(request), 32'd1);
    chk({tag, "_level_t1"}, 32'(queue_level), 32'd1);
    tick();                                   // T+2
    chk({tag, "_request_t2"}, 32'(request), 32'd0);
    tick();                                   // T+3
    chk({tag, "_pred_valid_t3"}, 32'(pred_valid), 32'd1);
    tick();                                   // T+4: resolve
    exec_valid = 1'b1;
    exec_taken = 1'b1;
    exp_res.push_back('{tk: 1'b1, mis: 1'b0});
    tick();
    exec_valid = 1'b0;
    exec_taken = 1'b0;
    chk({tag, "_result"}, 32'(result), 32'd1);
    chk({tag, "_level_after"}, 32'(queue_level), 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("reset_outputs", {20'(0), stall, request, pred_valid, pred_taken, result,
                          taken, mispredict, err_underrun, 1'b0, queue_level}, 32'd0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Scenario 1 + 3: single branch, correct resolve
    scenario1("s1");

    // Scenario 2: fetch held 6 cycles, queue fills at 4
    req_cnt = 0;
    pq.push_back(1'b1); pq.push_back(1'b0); pq.push_back(1'b1); pq.push_back(1'b1);
    exp_pred.push_back(1'b1); exp_pred.push_back(1'b0);
    exp_pred.push_back(1'b1); exp_pred.push_back(1'b1);
    fetch_branch = 1'b1;
    repeat (6) tick();
    fetch_branch = 1'b0;
    chk("s2_stall_full", 32'(stall), 32'd1);
    chk("s2_level_full", 32'(queue_level), 32'd4);
    repeat (4) tick();
    chk("s2_request_count", 32'(req_cnt), 32'd4);
    chk("s2_level_hold", 32'(queue_level), 32'd4);

    // Fetch while full with a correct resolve: no bypass, level 4 -> 3
    exec_valid = 1'b1; exec_taken = 1'b1; fetch_branch = 1'b1;
    exp_res.push_back('{tk: 1'b1, mis: 1'b0});
    tick();
    exec_valid = 1'b0; exec_taken = 1'b0; fetch_branch = 1'b0;
    chk("full_resolve_level", 32'(queue_level), 32'd3);
    chk("full_resolve_stall", 32'(stall), 32'd0);
    tick();
    tick();
    chk("full_no_bypass_req", 32'(req_cnt), 32'd4);
    chk("underrun_clear", 32'(err_underrun), 32'd0);

    // Scenario 4: oldest predicted 0, outcome 1, fetch in same cycle dropped
    exec_valid = 1'b1; exec_taken = 1'b1; fetch_branch = 1'b1;
    exp_res.push_back('{tk: 1'b1, mis: 1'b1});
    tick();                                   // R+1
    exec_valid = 1'b0; exec_taken = 1'b0; fetch_branch = 1'b0;
    chk("s4_level_flushed", 32'(queue_level), 32'd0);
    chk("s4_stall_r1", 32'(stall), 32'd1);
    chk("s4_branch_count", 32'(branch_count), 32'(exp_stat(3)));
    chk("s4_miss_count", 32'(miss_count), 32'(exp_stat(1)));
    tick();                                   // R+2
    chk("s4_stall_r2", 32'(stall), 32'd1);
    tick();                                   // R+3
    chk("s4_stall_r3", 32'(stall), 32'd0);
    chk("s4_wrong_path_req", 32'(req_cnt), 32'd4);

    // Scenario 5: resolve on an empty queue
    exec_valid = 1'b1; exec_taken = 1'b0;
    tick();
    exec_valid = 1'b0;
    chk("s5_underrun_set", 32'(err_underrun), 32'd1);
    repeat (3) tick();
    chk("s5_underrun_sticky", 32'(err_underrun), 32'd1);
    chk("s5_no_count", 32'(branch_count), 32'(exp_stat(3)));

    // Fetch together with a correct resolve: level unchanged
    pq.push_back(1'b0); exp_pred.push_back(1'b0);
    fetch_branch = 1'b1;
    tick();
    fetch_branch = 1'b0;
    repeat (3) tick();
    pq.push_back(1'b1); exp_pred.push_back(1'b1);
    exp_res.push_back('{tk: 1'b0, mis: 1'b0});
    exec_valid = 1'b1; exec_taken = 1'b0; fetch_branch = 1'b1;
    tick();
    exec_valid = 1'b0; fetch_branch = 1'b0;
    chk("simul_level", 32'(queue_level), 32'd1);
    repeat (3) tick();
    exp_res.push_back('{tk: 1'b1, mis: 1'b0});
    exec_valid = 1'b1; exec_taken = 1'b1;
    tick();
    exec_valid = 1'b0; exec_taken = 1'b0;
    chk("simul_drain", 32'(queue_level), 32'd0);

    // Scenario 6: reset mid-recovery with two branches pending
    pq.push_back(1'b0); exp_pred.push_back(1'b0);
    fetch_branch = 1'b1;
    tick();
    fetch_branch = 1'b0;
    repeat (3) tick();                        // A captured
    pq.push_back(1'b1);                       // B, discarded by flush
    fetch_branch = 1'b1;
    tick();
    pq.push_back(1'b1);                       // C, discarded by flush
    tick();                                   // R
    fetch_branch = 1'b0;
    exec_valid = 1'b1; exec_taken = 1'b1;
    exp_res.push_back('{tk: 1'b1, mis: 1'b1});
    tick();                                   // R+1
    exec_valid = 1'b0; exec_taken = 1'b0;
    chk("s6_stall", 32'(stall), 32'd1);
    chk("s6_level", 32'(queue_level), 32'd0);
    chk("s6_branch_count", 32'(branch_count), 32'(exp_stat(6)));
    chk("s6_miss_count", 32'(miss_count), 32'(exp_stat(2)));
    tick();                                   // R+2, still recovering
    rst_n = 1'b0;
    #1;
    chk("s6_reset_outputs", {stall, request, pred_valid, pred_taken, result, taken,
                             mispredict, err_underrun, 1'b0, queue_level,
                             branch_count[12:0], 8'd0}, 32'd0);
    chk("s6_reset_miss", 32'(miss_count), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    scenario1("s6_after");

    repeat (3) tick();
    chk("sb_pred_drained", 32'(exp_pred.size()), 32'd0);
    chk("sb_res_drained", 32'(exp_res.size()), 32'd0);
    chk("predictor_drained", 32'(pq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
